mem_bist_ctrl: RTL and testbench
================================

# mem_bist_ctrl

Hardware initiator for the `memory_rtl` SRAM port: it writes a deterministic pattern to every location, reads each location back, compares the result against the regenerated pattern, and reports pass/fail. It drives the same `wr`/`rd`/`addr`/`wdata`/`rdata`/`response` interface that the self-checking bench drives, so it can be instantiated next to `memory_rtl` as an on-chip self-test engine.

## Interface
- `ADDR_WIDTH`, default 5: memory address width.
- `DATA_WIDTH`, default 32: memory data width.
- `MEM_SIZE`, default 32: number of locations tested (addresses 0..MEM_SIZE-1); MEM_SIZE ≤ 2^ADDR_WIDTH.
- `SEED`, default 'hA5: pattern base value.
- `STRIDE`, default 'h0101_0101: pattern increment per address.
- `TIMEOUT`, default 15: maximum number of cycles to wait for `mem_response` per read.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: begin a test run; sampled only in IDLE.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse at the end of a run.
- `pass` out, 1: high when `err_count`==0; valid from `done` until the next `start`.
- `err_count` out, ADDR_WIDTH+1: number of mismatches plus timeouts.
- `fail_addr` out, ADDR_WIDTH: address of the first failure; 0 if there is none.
- `mem_wr` out, 1: write strobe to memory.
- `mem_rd` out, 1: read strobe to memory.
- `mem_addr` out, ADDR_WIDTH: memory address.
- `mem_wdata` out, DATA_WIDTH: write data.
- `mem_rdata` in, DATA_WIDTH: read data from memory.
- `mem_response` in, 1: memory asserts this for one cycle when `mem_rdata` is valid for the outstanding read.

## Operation
- Pattern: pattern(i) = (SEED + i·STRIDE) mod 2^DATA_WIDTH. It is regenerated for the read pass and never stored.
- States and transitions:
  - IDLE → WRITE when `start`=1.
  - WRITE: one write per cycle, addresses 0..MEM_SIZE-1 → GAP.
  - GAP: 2 idle cycles with `mem_wr`=`mem_rd`=0 → READ.
  - READ: `mem_rd`=1 for one cycle at the current address → WAIT_RSP.
  - WAIT_RSP: wait for `mem_response`, then return to READ for the next address, or go to FIN after the last address.
  - FIN: pulse `done`, latch `pass` → IDLE.
- Compare rule:
  - On `mem_response`=1 in WAIT_RSP, compare `mem_rdata` against pattern(addr).
  - A mismatch increments `err_count`.
  - On the first failure, record `fail_addr`.
- Timeout rule: if `mem_response` stays low for TIMEOUT cycles in WAIT_RSP, count the read as a failure (same bookkeeping as a mismatch) and move to the next address.
- `mem_response` outside WAIT_RSP is ignored.
- `start` while busy is ignored.
- A new `start` clears `err_count`, `fail_addr` and `pass`.
- `err_count` cannot overflow, because its maximum value MEM_SIZE fits in ADDR_WIDTH+1 bits.

## Timing
- All outputs are registered.
- Reset values: `busy`=`done`=`pass`=0, `err_count`=0, `fail_addr`=0, `mem_wr`=`mem_rd`=0, `mem_addr`=0, `mem_wdata`=0; state=IDLE.
- Reset asserted mid-run: at the next edge every output returns to its reset value and any outstanding read is abandoned.
- Edge where `start`=1 in IDLE: `mem_wr`=1, `mem_addr`=0, `mem_wdata`=pattern(0). Each following edge advances the address by 1.
- The edge after the write at address MEM_SIZE-1 drops `mem_wr`; 2 GAP cycles follow.
- Each read is 1 cycle with `mem_rd`=1, then WAIT_RSP. `mem_rdata` is sampled on the edge where `mem_response`=1. The next READ starts on the following edge.
- Run length:
  - With a 1-cycle-latency memory: write takes MEM_SIZE cycles, gap 2, read 2·MEM_SIZE, FIN 1.
  - Defaults: `done` rises 99 cycles after `start`.
- `done`=1 for exactly one cycle. `busy` falls on the same edge as the FIN→IDLE transition.

## Structure
- Shared package `mem_bist_pkg`: state enum (IDLE, WRITE, GAP, READ, WAIT_RSP, FIN) and the pattern function.
- One sub-module, `mem_bist_patgen`: a DATA_WIDTH accumulator with `load` (load SEED) and `step` (add STRIDE) inputs. It is shared by the write and read passes.
- Top level: FSM, address counter, timeout counter, error bookkeeping.

## Test plan
- **Clean run.** Reset, then start against a 1-cycle-latency memory model → during the write pass, addr 3 sees `mem_wdata`=0x030303A8 and addr 31 sees 0x1F1F1FC4. `done` arrives 99 cycles after `start`, with `pass`=1 and `err_count`=0.
- **Single corrupted bit.** Model flips bit 0 of location 7 → `err_count`=1, `fail_addr`=7, `pass`=0.
- **Missing response.** Model withholds `mem_response` for addr 12 → addr 12 is abandoned after 15 cycles, the run continues through addr 31, and `err_count`=1, `fail_addr`=12.
- **Multiple failures.** Locations 4 and 20 corrupted → `err_count`=2, `fail_addr`=4.
- **Start handling.** `start` pulsed while busy → no effect on sequence or timing. A second `start` after `done` → counters cleared and the run repeats identically.
- **Reset mid-run.** `reset` asserted during the READ pass → next edge shows `mem_rd`=0, `busy`=0, `err_count`=0. A fresh `start` then completes with `pass`=1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller and its pattern generator.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    GAP      = 3'd2,
    READ     = 3'd3,
    WAIT_RSP = 3'd4,
    FIN      = 3'd5
  } state_e;

  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned PAT_MAX_W  = 64;

  // Caller truncates to its data width; the arithmetic wraps mod 2^DATA_WIDTH.
  function automatic logic [PAT_MAX_W-1:0] pattern_at(input logic [PAT_MAX_W-1:0] seed,
                                                      input logic [PAT_MAX_W-1:0] stride,
                                                      input logic [PAT_MAX_W-1:0] idx);
    return seed + idx * stride;
  endfunction

endpackage

// File: rtl/mem_bist_patgen.sv
// Pattern accumulator shared by the write and read passes: load restarts at
// pattern(0), step advances to the next address's pattern.
module mem_bist_patgen
  import mem_bist_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  SEED       = 'hA5,
  parameter logic [DATA_WIDTH-1:0]  STRIDE     = 'h0101_0101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  output logic [DATA_WIDTH-1:0] pat_o
);

  localparam logic [DATA_WIDTH-1:0] LOAD_VAL =
    DATA_WIDTH'(pattern_at(PAT_MAX_W'(SEED), PAT_MAX_W'(STRIDE), '0));

  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = LOAD_VAL;
    end else if (step_i) begin
      acc_d = acc_q + STRIDE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign pat_o = acc_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST initiator: write pattern pass, short gap, read/compare pass with
// per-read response timeout, then a one-cycle done pulse with pass/fail summary.
//   state    | meaning
//   IDLE     | waiting for start; results held
//   WRITE    | one write per cycle, addr 0..MEM_SIZE-1
//   GAP      | two quiet cycles between passes
//   READ     | single-cycle read strobe at current addr
//   WAIT_RSP | waiting for response or timeout, then compare
//   FIN      | latch pass, pulse done on exit
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 5,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            MEM_SIZE   = 32,
  parameter logic [DATA_WIDTH-1:0]  SEED       = 'hA5,
  parameter logic [DATA_WIDTH-1:0]  STRIDE     = 'h0101_0101,
  parameter int unsigned            TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response
);

  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [TMO_W-1:0]      TMO_LOAD  = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0]            GAP_LOAD  = 2'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            gap_q, gap_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ADDR_WIDTH:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  pat_load, pat_step;
  logic                  fail_now, advance;
  logic [DATA_WIDTH-1:0] pat;

  mem_bist_patgen #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEED       (SEED),
    .STRIDE     (STRIDE)
  ) u_patgen (
    .clk    (clk),
    .reset  (reset),
    .load_i (pat_load),
    .step_i (pat_step),
    .pat_o  (pat)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    pat_load = 1'b0;
    pat_step = 1'b0;
    fail_now = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WRITE;
          wr_d     = 1'b1;
          addr_d   = '0;
          pat_load = 1'b1;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
        end
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d  = GAP;
          gap_d    = GAP_LOAD;
          addr_d   = '0;
          pat_load = 1'b1;
        end else begin
          wr_d     = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'(1);
          pat_step = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = READ;
          rd_d    = 1'b1;
        end else begin
          gap_d = gap_q - 2'd1;
        end
      end
      READ: begin
        state_d = WAIT_RSP;
        tmo_d   = TMO_LOAD;
      end
      WAIT_RSP: begin
        // A missing response is booked exactly like a data mismatch.
        if (mem_response) begin
          fail_now = (mem_rdata != pat);
          advance  = 1'b1;
        end else if (tmo_q == '0) begin
          fail_now = 1'b1;
          advance  = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
        if (fail_now) begin
          err_d = err_q + (ADDR_WIDTH+1)'(1);
          if (err_q == '0) begin
            fail_d = addr_q;
          end
        end
        if (advance) begin
          if (addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            state_d  = READ;
            rd_d     = 1'b1;
            addr_d   = addr_q + ADDR_WIDTH'(1);
            pat_step = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;
  assign mem_wr    = wr_q;
  assign mem_rd    = rd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = pat;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl against a 1-cycle-latency memory model with
// injectable read corruption and withheld responses.
module tb_mem_bist_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, pass;
  logic [5:0]  err_count;
  logic [4:0]  fail_addr;
  logic        mem_wr, mem_rd;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_response = 1'b0;

  int bad0 = -1, bad1 = -1, hold_addr = -1;
  int total = 0, passed = 0;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  mem_bist_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .fail_addr    (fail_addr),
    .mem_wr       (mem_wr),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_response (mem_response)
  );

  // Memory model: reads answer one cycle later; bit 0 flipped on "bad" addresses.
  always @(posedge clk) begin
    mem_response <= 1'b0;
    if (!reset) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd && int'(mem_addr) != hold_addr) begin
        mem_response <= 1'b1;
        mem_rdata    <= mem[mem_addr] ^
                        ((int'(mem_addr) == bad0 || int'(mem_addr) == bad1) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic run(input int mid, output int lat, output int nwr, output int wbad,
                     output int nrd, output int bbad, output logic [31:0] w3,
                     output logic [31:0] w31);
    lat = 0; nwr = 0; wbad = 0; nrd = 0; bbad = 0; w3 = '0; w31 = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_clears_err", err_count, 0);
    check("start_clears_pass", pass, 0);
    while (!done && lat < 400) begin
      if (mem_wr) begin
        nwr++;
        if (mem_wdata != 32'hA5 + 32'(mem_addr) * 32'h0101_0101) wbad++;
        if (mem_addr == 5'd3)  w3  = mem_wdata;
        if (mem_addr == 5'd31) w31 = mem_wdata;
      end
      if (mem_rd) nrd++;
      if (!busy) bbad++;
      start = (mid != 0 && lat == mid);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string name;
    int    b0, b1, hold, mid;
    int    exp_err, exp_fail, exp_pass, exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, nwr, wbad, nrd, bbad;
    logic [31:0] w3, w31;

    vecs[0] = '{"clean",      -1, -1, -1,  0, 0,  0, 1,  99};
    vecs[1] = '{"bit7",        7, -1, -1,  0, 1,  7, 0,  99};
    vecs[2] = '{"noresp12",   -1, -1, 12,  0, 1, 12, 0, 113};
    vecs[3] = '{"multi4_20",   4, 20, -1,  0, 2,  4, 0,  99};
    vecs[4] = '{"start_busy", -1, -1, -1, 50, 0,  0, 1,  99};
    vecs[5] = '{"rerun",      -1, -1, -1,  5, 0,  0, 1,  99};

    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_wr_rd", {mem_wr, mem_rd}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      bad0 = vecs[i].b0; bad1 = vecs[i].b1; hold_addr = vecs[i].hold;
      run(vecs[i].mid, lat, nwr, wbad, nrd, bbad, w3, w31);
      check({vecs[i].name, "_no_timeout"}, (lat < 400), 1);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_err"}, err_count, vecs[i].exp_err);
      check({vecs[i].name, "_fail_addr"}, fail_addr, vecs[i].exp_fail);
      check({vecs[i].name, "_pass"}, pass, vecs[i].exp_pass);
      check({vecs[i].name, "_busy_at_done"}, busy, 0);
      check({vecs[i].name, "_busy_during"}, bbad, 0);
      check({vecs[i].name, "_writes"}, nwr, 32);
      check({vecs[i].name, "_wdata_bad"}, wbad, 0);
      check({vecs[i].name, "_reads"}, nrd, 32);
      check({vecs[i].name, "_wdata3"}, w3, 32'h0303_03A8);
      check({vecs[i].name, "_wdata31"}, w31, 32'h1F1F_1FC4);
      @(negedge clk);
      check({vecs[i].name, "_done_one_cycle"}, done, 0);
      check({vecs[i].name, "_pass_held"}, pass, vecs[i].exp_pass);
      repeat (2) @(negedge clk);
    end

    // Reset during the read pass, after addr 0 has already failed.
    bad0 = 0; bad1 = -1; hold_addr = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_pre_err", err_count, 1);
    check("midrst_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rd", mem_rd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err_count, 0);
    check("midrst_fail_addr", fail_addr, 0);
    check("midrst_addr", mem_addr, 0);
    reset = 1'b0;
    bad0 = -1;
    repeat (2) @(negedge clk);
    run(0, lat, nwr, wbad, nrd, bbad, w3, w31);
    check("after_rst_latency", lat, 99);
    check("after_rst_pass", pass, 1);
    check("after_rst_err", err_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
